// File: rtl/lfsr_pkg.sv
// lfsr_pkg: LFSR step function shared by the feedback logic, plus primitive tap masks.
package lfsr_pkg;
   localparam int MAX_W = 64;
   localparam logic [MAX_W-1:0] TAPS_3  = 'h6;
   localparam logic [MAX_W-1:0] TAPS_4  = 'hC;
   localparam logic [MAX_W-1:0] TAPS_8  = 'hB8;
   localparam logic [MAX_W-1:0] TAPS_16 = 'hB400;
   function automatic logic [MAX_W-1:0] lfsr_mask(input int width);
      return (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
   endfunction
   function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] state, input logic [MAX_W-1:0] taps,
                                                  input logic [MAX_W-1:0] seed, input int width);
      logic [MAX_W-1:0] s;
      s = state & lfsr_mask(width);
      // all-zero is the XOR-form lock-up state; escape it by reloading the seed
      return (s == '0) ? (seed & lfsr_mask(width)) : (((s << 1) | MAX_W'(^(s & taps))) & lfsr_mask(width));
   endfunction
endpackage

// File: rtl/lfsr_feedback.sv
// lfsr_feedback: combinational next-state for a Fibonacci XOR LFSR, shifting toward the MSB.
module lfsr_feedback import lfsr_pkg::*; #(
   parameter int               WIDTH    = 3,
   parameter logic [MAX_W-1:0] TAPS     = TAPS_3,
   parameter logic [WIDTH-1:0] SEED_EFF = 1
) (
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] next_o
);
   always_comb next_o = WIDTH'(lfsr_next(MAX_W'(state_i), TAPS, MAX_W'(SEED_EFF), WIDTH));
endmodule

// File: rtl/lfsr.sv
// lfsr: free-running Fibonacci LFSR; the registered state is the output.
module lfsr import lfsr_pkg::*; #(
   parameter int               WIDTH = 3,
   parameter logic [MAX_W-1:0] TAPS  = TAPS_3,
   parameter logic [MAX_W-1:0] SEED  = 1
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] data
);
   localparam logic [WIDTH-1:0] SEED_T   = SEED[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED_T == '0) ? WIDTH'(1) : SEED_T;
   logic [WIDTH-1:0] data_q, data_d;
   if (WIDTH < 2) begin : g_err_width
      $error("lfsr: WIDTH must be at least 2");
   end
   if (WIDTH > MAX_W) begin : g_err_max
      $error("lfsr: WIDTH exceeds MAX_W");
   end
   if ((TAPS & lfsr_mask(WIDTH)) == '0) begin : g_err_taps
      $error("lfsr: TAPS has no bits inside WIDTH");
   end
   if (!TAPS[WIDTH-1]) begin : g_err_msb
      $error("lfsr: TAPS[WIDTH-1] must be set");
   end
   lfsr_feedback #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED_EFF(SEED_EFF)) u_fb (
      .state_i (data_q),
      .next_o  (data_d)
   );
   always_ff @(posedge clk) data_q <= reset ? SEED_EFF : data_d;
   assign data = data_q;
endmodule

// File: tb/tb_lfsr.sv
// tb_lfsr: scoreboard bench for lfsr across default, zero-seed, 4-bit and 8-bit configurations.
module tb_lfsr;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] d3, d0;
   logic [3:0] d4;
   logic [7:0] d8;
   logic [7:0] exp_q[$];
   logic [2:0] seq[7] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4};
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   lfsr u3 (.clk(clk), .reset(reset), .data(d3));
   lfsr #(.SEED(0)) u0 (.clk(clk), .reset(reset), .data(d0));
   lfsr #(.WIDTH(4), .TAPS('hC), .SEED(1)) u4 (.clk(clk), .reset(reset), .data(d4));
   lfsr #(.WIDTH(8), .TAPS('hB8), .SEED('hA5)) u8 (.clk(clk), .reset(reset), .data(d8));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_q.push_back(8'd1);
      exp_q.push_back(8'd1);
      exp_q.push_back(8'd1);
      exp_q.push_back(8'hA5);
      n_cmp++; if ({5'd0, d3} !== exp_q[0]) begin n_bad++; $display("FAIL reset_w3: got %0h expected %0h", d3, exp_q[0]); end
      n_cmp++; if ({5'd0, d0} !== exp_q[1]) begin n_bad++; $display("FAIL reset_seed0: got %0h expected %0h", d0, exp_q[1]); end
      n_cmp++; if ({4'd0, d4} !== exp_q[2]) begin n_bad++; $display("FAIL reset_w4: got %0h expected %0h", d4, exp_q[2]); end
      n_cmp++; if (d8 !== exp_q[3]) begin n_bad++; $display("FAIL reset_w8: got %0h expected %0h", d8, exp_q[3]); end
      exp_q.delete();
   endtask

   task automatic test_default_seq();
      logic [7:0] e;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back({5'd0, seq[i % 7]});
      for (int i = 0; i < 8; i++) begin
         if (i > 0) step();
         e = exp_q.pop_front();
         n_cmp++; if ({5'd0, d3} !== e) begin n_bad++; $display("FAIL seq_default[%0d]: got %0h expected %0h", i, d3, e); end
         n_cmp++; if ({5'd0, d0} !== e) begin n_bad++; $display("FAIL seq_seed0[%0d]: got %0h expected %0h", i, d0, e); end
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] e;
      bit         found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         if (d3 === 3'd7) found = 1;
         else step();
      end
      n_cmp++; if (!found) begin n_bad++; $display("FAIL mid_reset_reach7: got %0h expected 7 within 10 cycles", d3); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_q.push_back(8'd1);
      exp_q.push_back(8'd2);
      exp_q.push_back(8'd5);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         e = exp_q.pop_front();
         n_cmp++; if ({5'd0, d3} !== e) begin n_bad++; $display("FAIL mid_reset[%0d]: got %0h expected %0h", i, d3, e); end
      end
   endtask

   task automatic test_reset_hold();
      logic [7:0] e;
      step();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         e = exp_q.pop_front();
         n_cmp++; if ({5'd0, d3} !== e) begin n_bad++; $display("FAIL reset_hold[%0d]: got %0h expected %0h", i, d3, e); end
      end
      reset = 1'b0;
   endtask

   task automatic test_w4_period();
      logic [3:0]  m = 4'd1;
      logic [15:0] seen = 16'h0002;
      logic [7:0]  e;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         m = {m[2:0], m[3] ^ m[2]};
         exp_q.push_back({4'd0, m});
         step();
         e = exp_q.pop_front();
         n_cmp++; if ({4'd0, d4} !== e) begin n_bad++; $display("FAIL w4_seq[%0d]: got %0h expected %0h", i, d4, e); end
         if (i < 14) begin
            n_cmp++; if (d4 === 4'd0 || seen[d4]) begin n_bad++; $display("FAIL w4_unique[%0d]: got %0h expected new nonzero value", i, d4); end
            seen[d4] = 1'b1;
         end
      end
      n_cmp++; if (d4 !== 4'd1) begin n_bad++; $display("FAIL w4_period: got %0h expected 1 after 15 steps", d4); end
      n_cmp++; if ($countones(seen) != 15) begin n_bad++; $display("FAIL w4_coverage: got %0d expected 15 values", $countones(seen)); end
   endtask

   task automatic test_w8_period();
      int cnt = 0;
      bit zero = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      do begin
         step();
         cnt++;
         if (d8 === 8'd0) zero = 1;
      end while (d8 !== 8'hA5 && cnt < 300);
      n_cmp++; if (cnt != 255) begin n_bad++; $display("FAIL w8_period: got %0d expected 255", cnt); end
      n_cmp++; if (zero) begin n_bad++; $display("FAIL w8_zero: got 1 expected 0 (zero state seen)"); end
   endtask

   initial begin
      test_reset();
      test_default_seq();
      test_mid_reset();
      test_reset_hold();
      test_w4_period();
      test_w8_period();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
